// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU control codes, FSM state codes, datapath select encodings and the control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RTYPE_EX = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BEQ      = 4'd8;
    localparam logic [3:0] S_ADDI_EX  = 4'd9;
    localparam logic [3:0] S_ADDI_WB  = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_HALT     = 4'd13;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       rf_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: yields the ALU control code and flags functs outside the subset.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       valid_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        valid_o    = 1'b1;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory-stall watchdog.
// Define MIPS_PERF_CNT_EN to build the cycle/instruction performance counters.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 0
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_rdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  pc_src,
    output logic        instr_done,
    output logic        halted,
    output logic [3:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    logic [3:0]  state_q, state_d;
    logic [31:0] wdog_q, wdog_d;
    logic        wdog_trip;
    logic        stall;
    logic [3:0]  dec_alu_ctrl;
    logic        dec_valid;
    ctrl_t       ctrl_c, ctrl;

    mips_alu_dec u_alu_dec (
        .funct_i    (funct),
        .alu_ctrl_o (dec_alu_ctrl),
        .valid_o    (dec_valid)
    );

    always_comb begin
        ctrl_c = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_ctrl  = ALU_ADD;
                ctrl_c.pc_src    = PC_ALU;
                ctrl_c.ir_we     = mem_rdy;
                ctrl_c.pc_we     = mem_rdy;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH;
                ctrl_c.alu_ctrl  = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.rf_we      = 1'b1;
                ctrl_c.reg_dst    = RD_RT;
                ctrl_c.mem_to_reg = M2R_MDR;
                ctrl_c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.mem_req    = 1'b1;
                ctrl_c.mem_we     = 1'b1;
                ctrl_c.iord       = 1'b1;
                ctrl_c.instr_done = mem_rdy;
            end
            S_RTYPE_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_RT;
                ctrl_c.alu_ctrl  = dec_alu_ctrl;
            end
            S_RTYPE_WB: begin
                ctrl_c.rf_we      = 1'b1;
                ctrl_c.reg_dst    = RD_RD;
                ctrl_c.mem_to_reg = M2R_ALUOUT;
                ctrl_c.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl_c.alu_src_a  = 1'b1;
                ctrl_c.alu_src_b  = SRCB_RT;
                ctrl_c.alu_ctrl   = ALU_SUB;
                ctrl_c.pc_src     = PC_ALUOUT;
                ctrl_c.pc_we      = zero;
                ctrl_c.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_c.rf_we      = 1'b1;
                ctrl_c.reg_dst    = RD_RT;
                ctrl_c.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pc_src     = PC_JUMP;
                ctrl_c.pc_we      = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so it is the link value written to $31
                ctrl_c.pc_src     = PC_JUMP;
                ctrl_c.pc_we      = 1'b1;
                ctrl_c.rf_we      = 1'b1;
                ctrl_c.reg_dst    = RD_RA;
                ctrl_c.mem_to_reg = M2R_PC;
                ctrl_c.instr_done = 1'b1;
            end
            S_HALT:  ctrl_c.halted = 1'b1;
            default: ;
        endcase
    end

    assign stall = ctrl_c.mem_req && !mem_rdy;

    always_comb begin
        wdog_d    = '0;
        wdog_trip = 1'b0;
        if (stall) begin
            wdog_d    = wdog_q + 32'd1;
            wdog_trip = (MEM_WAIT_MAX != 0) && (wdog_d == MEM_WAIT_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = dec_valid ? S_RTYPE_EX : S_HALT;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:    if (mem_rdy) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_BEQ, S_ADDI_WB, S_JUMP, S_JAL:
                        state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
        if (wdog_trip) state_d = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
        end
    end

    // Reset blanks every control output; the debug state still shows the register
    assign ctrl       = rst ? '0 : ctrl_c;
    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign iord       = ctrl.iord;
    assign ir_we      = ctrl.ir_we;
    assign pc_we      = ctrl.pc_we;
    assign rf_we      = ctrl.rf_we;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_ctrl   = ctrl.alu_ctrl;
    assign pc_src     = ctrl.pc_src;
    assign instr_done = ctrl.instr_done;
    assign halted     = ctrl.halted;
    assign state      = state_q;

`ifdef MIPS_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (ctrl_c.instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected control bundles are queued by
// the stimulus and popped/compared by an independent monitor on the falling edge.
`timescale 1ns/1ps
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_rdy = 1'b0;
    logic        mem_req, mem_we, iord, ir_we, pc_we, rf_we;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic        alu_src_a, instr_done, halted;
    logic [3:0]  alu_ctrl, state;
    logic [31:0] cycle_cnt, instr_cnt;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MEM_WAIT_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_rdy    (mem_rdy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .halted     (halted),
        .state      (state),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    // strobes = {mem_req, mem_we, iord, ir_we, pc_we, rf_we}
    typedef struct packed {
        logic [3:0] st;
        logic [5:0] strobes;
        logic [1:0] regDst;
        logic [1:0] memToReg;
        logic       srcA;
        logic [1:0] srcB;
        logic [3:0] alu;
        logic [1:0] pcSrc;
        logic       done;
        logic       halt;
    } obs_t;

    obs_t  expQ[$];
    string nameQ[$];
    obs_t  monExp, monAct;
    string monName;
    int    total = 0;
    int    bad = 0;

    obs_t E_FETCH, E_FSTALL, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_RWB;
    obs_t E_ADDI_EX, E_ADDI_WB, E_JUMP, E_JAL, E_HALT, E_ZERO;

    function automatic obs_t ob(input logic [3:0] st, input logic [5:0] sb,
                                input logic [1:0] rd, input logic [1:0] m2r,
                                input logic sa, input logic [1:0] sbSel,
                                input logic [3:0] alu, input logic [1:0] ps,
                                input logic dn, input logic hl);
        return obs_t'({st, sb, rd, m2r, sa, sbSel, alu, ps, dn, hl});
    endfunction

    function automatic obs_t sample();
        return obs_t'({state, mem_req, mem_we, iord, ir_we, pc_we, rf_we, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done, halted});
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d strb=%b rd=%b m2r=%b a=%b b=%b alu=%b pc=%b done=%b halt=%b",
                         o.st, o.strobes, o.regDst, o.memToReg, o.srcA, o.srcB, o.alu,
                         o.pcSrc, o.done, o.halt);
    endfunction

    // Monitor: pops one expectation per falling edge whenever the stimulus queued one
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                monExp  = expQ.pop_front();
                monName = nameQ.pop_front();
                monAct  = sample();
                total++;
                if (monAct !== monExp) begin
                    bad++;
                    $display("[TB] FAIL %s: got {%s} expected {%s}", monName, fmt(monAct), fmt(monExp));
                end
            end
        end
    end

    task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy, input obs_t e, input string n);
        @(posedge clk);
        #1;
        rst     = r;
        opcode  = op;
        funct   = fn;
        zero    = z;
        mem_rdy = rdy;
        expQ.push_back(e);
        nameQ.push_back(n);
    endtask

    task automatic runFD(input logic [5:0] op, input logic [5:0] fn, input int fetchStalls,
                         input string n);
        for (int i = 0; i < fetchStalls; i++)
            applyStimulus(1'b0, op, fn, 1'b0, 1'b0, E_FSTALL, {n, "/fetchwait"});
        applyStimulus(1'b0, op, fn, 1'b0, 1'b1, E_FETCH, {n, "/fetch"});
        applyStimulus(1'b0, op, fn, 1'b0, 1'b1, E_DECODE, {n, "/decode"});
    endtask

    task automatic doRtype(input logic [5:0] fn, input logic [3:0] alu, input string n);
        runFD(6'h00, fn, 0, n);
        applyStimulus(1'b0, 6'h00, fn, 1'b0, 1'b1, ob(4'd6, 6'b0, 2'd0, 2'd0, 1'b1, 2'd0, alu, 2'd0, 1'b0, 1'b0), {n, "/ex"});
        applyStimulus(1'b0, 6'h00, fn, 1'b0, 1'b1, E_RWB, {n, "/wb"});
    endtask

    task automatic doLw(input int stalls);
        runFD(6'h23, 6'h00, 0, "lw");
        applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, E_MEMADR, "lw/adr");
        for (int i = 0; i < stalls; i++)
            applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, E_MEMRD, "lw/rdwait");
        applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, E_MEMRD, "lw/rd");
        applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, E_MEMWB, "lw/wb");
    endtask

    task automatic doSw(input int fetchStalls, input int stalls);
        runFD(6'h2B, 6'h00, fetchStalls, "sw");
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, E_MEMADR, "sw/adr");
        for (int i = 0; i < stalls; i++)
            applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, ob(4'd5, 6'b111000, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0), "sw/wrwait");
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, ob(4'd5, 6'b111000, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0), "sw/wr");
    endtask

    task automatic doBeq(input logic z);
        runFD(6'h04, 6'h00, 0, "beq");
        applyStimulus(1'b0, 6'h04, 6'h00, z, 1'b1, ob(4'd8, {4'b0000, z, 1'b0}, 2'd0, 2'd0, 1'b1, 2'd0, 4'b0110, 2'd1, 1'b1, 1'b0), z ? "beq/taken" : "beq/nottaken");
    endtask

    initial begin
        E_FETCH   = ob(4'd0,  6'b100110, 2'd0, 2'd0, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0);
        E_FSTALL  = ob(4'd0,  6'b100000, 2'd0, 2'd0, 1'b0, 2'd1, 4'b0010, 2'd0, 1'b0, 1'b0);
        E_DECODE  = ob(4'd1,  6'b000000, 2'd0, 2'd0, 1'b0, 2'd3, 4'b0010, 2'd0, 1'b0, 1'b0);
        E_MEMADR  = ob(4'd2,  6'b000000, 2'd0, 2'd0, 1'b1, 2'd2, 4'b0010, 2'd0, 1'b0, 1'b0);
        E_MEMRD   = ob(4'd3,  6'b101000, 2'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
        E_MEMWB   = ob(4'd4,  6'b000001, 2'd0, 2'd1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0);
        E_RWB     = ob(4'd7,  6'b000001, 2'd1, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0);
        E_ADDI_EX = ob(4'd9,  6'b000000, 2'd0, 2'd0, 1'b1, 2'd2, 4'b0010, 2'd0, 1'b0, 1'b0);
        E_ADDI_WB = ob(4'd10, 6'b000001, 2'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b1, 1'b0);
        E_JUMP    = ob(4'd11, 6'b000010, 2'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b1, 1'b0);
        E_JAL     = ob(4'd12, 6'b000011, 2'd2, 2'd2, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b1, 1'b0);
        E_HALT    = ob(4'd13, 6'b000000, 2'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b1);
        E_ZERO    = ob(4'd0,  6'b000000, 2'd0, 2'd0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset: state FETCH, all controls blanked even with mem_rdy high
        applyStimulus(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, E_ZERO, "reset");
        applyStimulus(1'b1, 6'h23, 6'h00, 1'b1, 1'b1, E_ZERO, "reset/held");

        // add $t0,$t1,$t2 = 0x012A4020, then the rest of the R-type subset
        doRtype(6'h20, 4'b0010, "add");
        doRtype(6'h22, 4'b0110, "sub");
        doRtype(6'h24, 4'b0000, "and");
        doRtype(6'h25, 4'b0001, "or");
        doRtype(6'h2A, 4'b0111, "slt");

        doLw(2);
        doSw(1, 1);
        doBeq(1'b1);
        doBeq(1'b0);

        runFD(6'h08, 6'h00, 0, "addi");
        applyStimulus(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, E_ADDI_EX, "addi/ex");
        applyStimulus(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, E_ADDI_WB, "addi/wb");

        runFD(6'h02, 6'h00, 0, "j");
        applyStimulus(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, E_JUMP, "j/jump");

        // jal 0x0C000C05
        runFD(6'h03, 6'h05, 0, "jal");
        applyStimulus(1'b0, 6'h03, 6'h05, 1'b0, 1'b1, E_JAL, "jal/jal");

        // Reset while a store is waiting in MEMWR abandons it
        runFD(6'h2B, 6'h00, 0, "swrst");
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, E_MEMADR, "swrst/adr");
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, ob(4'd5, 6'b111000, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0), "swrst/wrwait");
        applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, ob(4'd5, 6'b0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0), "swrst/rst");
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, E_FSTALL, "swrst/fetch");

        // Unknown opcode halts and stays quiet until reset
        runFD(6'h3F, 6'h00, 0, "badop");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 6'h3F, 6'h00, 1'b1, 1'b1, E_HALT, "badop/halt");
        applyStimulus(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, ob(4'd13, 6'b0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0), "badop/rst");

        // R-type with funct 0x00 also halts
        runFD(6'h00, 6'h00, 0, "badfn");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, E_HALT, "badfn/halt");
        applyStimulus(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, ob(4'd13, 6'b0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0), "badfn/rst");

        // Watchdog: 8 stalled fetch cycles, then HALT
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 6'h00, 6'h20, 1'b0, 1'b0, E_FSTALL, "wdog/wait");
        applyStimulus(1'b0, 6'h00, 6'h20, 1'b0, 1'b0, E_HALT, "wdog/halt");
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, ob(4'd13, 6'b0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0), "wdog/rst");

        // 30-instruction loop: 10 add (4 cyc) + 10 beq (3 cyc) + 10 lw (5 cyc) = 120 cycles
        for (int i = 0; i < 10; i++) begin
            doRtype(6'h20, 4'b0010, "loop/add");
            doBeq(i[0]);
            doLw(0);
        end
        @(posedge clk);
        #1;
`ifdef MIPS_PERF_CNT_EN
        checkOutput("perf/instr_cnt", instr_cnt, 32'd30);
        checkOutput("perf/cycle_cnt", cycle_cnt, 32'd120);
`else
        checkOutput("perf/instr_cnt_off", instr_cnt, 32'd0);
        checkOutput("perf/cycle_cnt_off", cycle_cnt, 32'd0);
`endif

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard: %0d expectations left, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("[TB] FAIL timeout: simulation still running, required to finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control FSM that sequences the shared MIPS datapath (PC, IR, register file, ALU, unified instruction/data memory port) one state per cycle. It replaces the single-cycle decoder for the instruction subset add, sub, and, or, slt, addi, lw, sw, beq, j, jal. It sits between the IR opcode/funct fields and the datapath mux selects and write strobes. It stalls on a memory ready handshake.

Parameters:
MEM_WAIT_MAX, 0, watchdog on mem_rdy; 0 = disabled, else HALT after this many consecutive stalled cycles.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_rdy  in  1  memory accepted read/write this cycle
mem_req  out  1  memory access request
mem_we  out  1  write (valid with mem_req)
iord  out  1  address select: 0 PC, 1 ALUOut
ir_we, pc_we, rf_we  out  1 each  IR / PC / regfile write strobes
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (PC+4)
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
pc_src  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28], IR[25:0], 2'b00}
instr_done  out  1  one-cycle pulse in final state of each instruction
halted  out  1  FSM in HALT
state  out  4  current state, for debug
cycle_cnt, instr_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- rst sampled on clk edge: state <= FETCH, watchdog and counters <= 0. While rst is high, every control output is forced to 0. Reset mid-instruction abandons it with no further writes.
- Outputs are Moore, decoded from the state register. Unlisted strobes are 0 and selects are 00.
- FETCH(0): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00; ir_we=pc_we=mem_rdy. Stays in FETCH until mem_rdy, then DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, ADD (ALUOut = branch target). Dispatch: lw/sw->MEMADR, R->RTYPE_EX, beq->BEQ, addi->ADDI_EX, j->JUMP, jal->JAL. Unknown opcode, or R-type with unknown funct, -> HALT.
- MEMADR(2): alu_src_a=1, alu_src_b=10, ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD(3): mem_req=1, iord=1. Waits for mem_rdy, then MEMWB.
- MEMWB(4): rf_we=1, reg_dst=00, mem_to_reg=01, instr_done -> FETCH.
- MEMWR(5): mem_req=mem_we=iord=1, held stable until mem_rdy; instr_done on the mem_rdy cycle -> FETCH.
- RTYPE_EX(6): alu_src_a=1, alu_src_b=00, alu_ctrl from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT) -> RTYPE_WB(7).
- RTYPE_WB(7): rf_we, reg_dst=01, mem_to_reg=00, instr_done -> FETCH.
- BEQ(8): alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=zero, instr_done -> FETCH.
- ADDI_EX(9): alu_src_a=1, alu_src_b=10, ADD -> ADDI_WB(10).
- ADDI_WB(10): rf_we, reg_dst=00, instr_done -> FETCH.
- JUMP(11): pc_src=10, pc_we, instr_done -> FETCH.
- JAL(12): pc_src=10, pc_we, rf_we, reg_dst=10, mem_to_reg=10, instr_done -> FETCH. The regfile writes the pre-jump PC, which already holds PC+4.
- HALT(13): all strobes 0, halted=1. Sticky until rst.
- Latency with mem_rdy=1: beq/j/jal 3 cycles, R/addi/sw 4, lw 5. Each stall cycle adds 1.
- Watchdog: counts consecutive cycles with mem_req && !mem_rdy and clears on mem_rdy. Reaching MEM_WAIT_MAX sends the FSM to HALT.

Optional Feature:
MIPS_PERF_CNT_EN. When defined, cycle_cnt increments every non-reset cycle in which the FSM is not in HALT, and instr_cnt increments on instr_done. Both are 32-bit, wrap modulo 2^32, and clear on rst. When undefined, both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mips_pkg: opcode and funct constants, ALU control codes, state enum (4-bit), and reg_dst/mem_to_reg/alu_src_b/pc_src encodings.
- Sub-module mips_alu_dec: combinational funct -> alu_ctrl plus a valid flag; the FSM uses the flag for the HALT dispatch.

Test Plan:
- add $t0,$t1,$t2 (0x012A4020) with mem_rdy=1 -> states 0,1,6,7; rf_we=1 and reg_dst=01 in cycle 4; instr_done pulses once.
- lw with mem_rdy low 2 extra cycles in MEMRD -> mem_req and iord held at 1; total 7 cycles; rf_we with mem_to_reg=01.
- beq with zero=1, then with zero=0 -> pc_we=1 with pc_src=01 in cycle 3 / pc_we=0; both return to FETCH.
- jal (0x0C000C05) -> cycle 3 asserts pc_we, rf_we, reg_dst=10, mem_to_reg=10, pc_src=10.
- Opcode 0x3F, or R-type funct 0x00 -> HALT, halted=1, no strobes for 10 cycles; rst clears halted. With MEM_WAIT_MAX=8 and mem_rdy stuck low in FETCH -> HALT after 8 cycles.
- rst asserted in MEMWR -> next cycle state=FETCH, no mem_we. With MIPS_PERF_CNT_EN, the 30-instruction loop program gives instr_cnt=30.
